// File: rtl/multicycle_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_fsm
//
// Multicycle control unit for an RV32I/RV64I datapath. Sequences fetch,
// decode, execute, memory and writeback, and drives every datapath strobe.
// Memory accesses use a req/ready handshake with an optional bounded wait;
// branches are resolved here from the ALU flags; an unknown instruction or
// a memory timeout parks the unit in TRAP, and ebreak/ecall parks it in HALT.
//
// Parameters:
//   MEM_TIMEOUT  cycles to wait for mem_ready before faulting (0 = no limit)
//   TO_W         wait counter width, must hold MEM_TIMEOUT
//   XLEN         datapath width, used only to check the shift amount
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   opcode/funct3/funct7       instruction register decode fields
//   mem_ready                  memory completes the current request
//   alu_zero, alu_lt           ALU result flags for branch resolution
//   state_out                  current state encoding (debug)
//   mem_req/mem_we/mem_iord    memory request, write, address select
//   ir/a/b/aout/mdr_load       datapath register enables
//   pc_write, pc_src           PC load and source select
//   reg_write, wb_sel          register file write and source select
//   alu_src_a/b, alu_op        ALU operand selects and operation
//   shift_op                   shifter operation
//   halted, fault              sticky status flags
//
// Optional build macro CTRL_PERF_CNT_EN adds retired_cnt and stall_cnt.
// ---------------------------------------------------------------------------
module multicycle_ctrl_fsm #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned TO_W        = 5,
  parameter int unsigned XLEN        = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic        mem_ready,
  input  logic        alu_zero,
  input  logic        alu_lt,
  output logic [4:0]  state_out,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_iord,
  output logic        ir_load,
  output logic        a_load,
  output logic        b_load,
  output logic        aout_load,
  output logic        mdr_load,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  alu_op,
  output logic [1:0]  shift_op,
  output logic        halted,
`ifdef CTRL_PERF_CNT_EN
  output logic [31:0] retired_cnt,
  output logic [31:0] stall_cnt,
`endif
  output logic        fault
);

  typedef enum logic [4:0] {
    StIdle   = 5'd0,
    StFetch  = 5'd1,
    StDecode = 5'd2,
    StExeR   = 5'd3,
    StExeI   = 5'd4,
    StAddr   = 5'd5,
    StMemRd  = 5'd6,
    StMemWr  = 5'd7,
    StWbAlu  = 5'd8,
    StWbMem  = 5'd9,
    StBranch = 5'd10,
    StLui    = 5'd11,
    StJal    = 5'd12,
    StJalr   = 5'd13,
    StShift  = 5'd14,
    StHalt   = 5'd30,
    StTrap   = 5'd31
  } state_e;

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  localparam logic [2:0] AluPass = 3'b000;
  localparam logic [2:0] AluAdd  = 3'b001;
  localparam logic [2:0] AluSub  = 3'b010;
  localparam logic [2:0] AluAnd  = 3'b011;
  localparam logic [2:0] AluSlt  = 3'b111;

  localparam logic [TO_W:0] TimeoutVal = MEM_TIMEOUT[TO_W:0];

  state_e          state_q, state_d;
  logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
  logic            halted_q, halted_d;
  logic            fault_q, fault_d;

  // Instruction legality, evaluated while in DECODE.
  logic r_legal, shamt_ok, shift_legal, br_legal;
  logic mem_wait, timeout;
  logic [TO_W:0] cnt_inc;

  always_comb begin
    r_legal = ((funct7 == 7'b0000000) &&
               (funct3 == 3'b000 || funct3 == 3'b111 || funct3 == 3'b010)) ||
              ((funct7 == 7'b0100000) && (funct3 == 3'b000));
    // funct7[0] is shamt[5]; only legal when the datapath is 64 bits wide.
    shamt_ok    = (XLEN == 32) ? !funct7[0] : 1'b1;
    shift_legal = 1'b0;
    if (funct3 == 3'b001) begin
      shift_legal = (funct7[6:1] == 6'b000000) && shamt_ok;
    end else if (funct3 == 3'b101) begin
      shift_legal = ((funct7[6:1] == 6'b000000) || (funct7[6:1] == 6'b010000)) && shamt_ok;
    end
    br_legal = (funct3 == 3'b000) || (funct3 == 3'b001) ||
               (funct3 == 3'b100) || (funct3 == 3'b101);
  end

  // The wait counter holds the number of ready-less cycles already spent in
  // the current wait state. A timeout fires in the cycle whose miss would
  // bring that count up to MEM_TIMEOUT; ready in that same cycle still wins.
  assign mem_wait = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
  assign cnt_inc  = {1'b0, wait_cnt_q} + 1'b1;
  assign timeout  = (MEM_TIMEOUT != 0) && !mem_ready && (cnt_inc == TimeoutVal);

  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_iord  = 1'b0;
    ir_load   = 1'b0;
    a_load    = 1'b0;
    b_load    = 1'b0;
    aout_load = 1'b0;
    mdr_load  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 2'b00;
    reg_write = 1'b0;
    wb_sel    = 2'b00;
    alu_src_a = 2'b00;
    alu_src_b = 2'b00;
    alu_op    = AluPass;
    shift_op  = 2'b00;

    case (state_q)
      StIdle: state_d = StFetch;

      StFetch: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          // Latch IR and advance PC by 4 in the same cycle.
          ir_load   = 1'b1;
          pc_write  = 1'b1;
          alu_src_b = 2'b01;
          alu_op    = AluAdd;
          state_d   = StDecode;
        end else if (timeout) begin
          state_d = StTrap;
        end
      end

      StDecode: begin
        a_load    = 1'b1;
        b_load    = 1'b1;
        aout_load = 1'b1;
        alu_src_b = 2'b11;  // speculative branch/jal target PC+(imm<<1)
        alu_op    = AluAdd;
        case (opcode)
          OpR: state_d = r_legal ? StExeR : StTrap;
          OpImm: begin
            if (funct3 == 3'b000 || funct3 == 3'b010) begin
              state_d = StExeI;
            end else if (shift_legal) begin
              state_d = StShift;
            end else begin
              state_d = StTrap;
            end
          end
          OpLoad, OpStore: state_d = StAddr;
          OpBranch:        state_d = br_legal ? StBranch : StTrap;
          OpLui:           state_d = StLui;
          OpJal:           state_d = StJal;
          OpJalr:          state_d = StJalr;
          OpSystem:        state_d = StHalt;
          default:         state_d = StTrap;
        endcase
      end

      StExeR: begin
        alu_src_a = 2'b01;
        aout_load = 1'b1;
        case ({funct7[5], funct3})
          4'b0_000: alu_op = AluAdd;
          4'b1_000: alu_op = AluSub;
          4'b0_111: alu_op = AluAnd;
          4'b0_010: alu_op = AluSlt;
          default:  alu_op = AluPass;
        endcase
        state_d = StWbAlu;
      end

      StExeI: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        aout_load = 1'b1;
        alu_op    = (funct3 == 3'b010) ? AluSlt : AluAdd;
        state_d   = StWbAlu;
      end

      StWbAlu: begin
        reg_write = 1'b1;
        state_d   = StFetch;
      end

      StShift: begin
        // Shifter result is captured in AOut and written back the same cycle.
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        aout_load = 1'b1;
        reg_write = 1'b1;
        if (funct3 == 3'b101) begin
          shift_op = funct7[5] ? 2'b10 : 2'b01;
        end
        state_d = StFetch;
      end

      StAddr: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        alu_op    = AluAdd;
        aout_load = 1'b1;
        state_d   = (opcode == OpLoad) ? StMemRd : StMemWr;
      end

      StMemRd: begin
        mem_req  = 1'b1;
        mem_iord = 1'b1;
        if (mem_ready) begin
          mdr_load = 1'b1;
          state_d  = StWbMem;
        end else if (timeout) begin
          state_d = StTrap;
        end
      end

      StMemWr: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_iord = 1'b1;
        if (mem_ready) begin
          state_d = StFetch;
        end else if (timeout) begin
          state_d = StTrap;
        end
      end

      StWbMem: begin
        reg_write = 1'b1;
        wb_sel    = 2'b01;
        state_d   = StFetch;
      end

      StBranch: begin
        alu_src_a = 2'b01;
        pc_src    = 2'b01;
        alu_op    = funct3[2] ? AluSlt : AluSub;
        case (funct3)
          3'b000:  pc_write = alu_zero;
          3'b001:  pc_write = !alu_zero;
          3'b100:  pc_write = alu_lt;
          3'b101:  pc_write = !alu_lt;
          default: pc_write = 1'b0;
        endcase
        state_d = StFetch;
      end

      StLui: begin
        reg_write = 1'b1;
        wb_sel    = 2'b10;
        state_d   = StFetch;
      end

      StJal: begin
        // Link value is the already-incremented PC.
        reg_write = 1'b1;
        wb_sel    = 2'b11;
        pc_write  = 1'b1;
        pc_src    = 2'b01;
        state_d   = StFetch;
      end

      StJalr: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        alu_op    = AluAdd;
        reg_write = 1'b1;
        wb_sel    = 2'b11;
        pc_write  = 1'b1;
        pc_src    = 2'b10;
        state_d   = StFetch;
      end

      StHalt, StTrap: state_d = state_q;

      default: state_d = StTrap;
    endcase
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_d != state_q) begin
      wait_cnt_d = '0;
    end else if (mem_wait && !mem_ready && (wait_cnt_q != {TO_W{1'b1}})) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
    halted_d = halted_q | (state_d == StHalt);
    fault_d  = fault_q | (state_d == StTrap);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      wait_cnt_q <= '0;
      halted_q   <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      halted_q   <= halted_d;
      fault_q    <= fault_d;
    end
  end

  assign state_out = state_q;
  assign halted    = halted_q;
  assign fault     = fault_q;

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] retired_q, stall_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      // Every return to FETCH other than the first one out of IDLE retires.
      if ((state_d == StFetch) && (state_q != StFetch) && (state_q != StIdle)) begin
        retired_q <= retired_q + 32'd1;
      end
      if (mem_req && !mem_ready) begin
        stall_q <= stall_q + 32'd1;
      end
    end
  end

  assign retired_cnt = retired_q;
  assign stall_cnt   = stall_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
module tb_multicycle_ctrl_fsm;

  logic        clk;
  logic        reset;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        mem_ready, alu_zero, alu_lt;
  logic [4:0]  state_out;
  logic        mem_req, mem_we, mem_iord, ir_load, a_load, b_load, aout_load, mdr_load;
  logic        pc_write, reg_write, halted, fault;
  logic [1:0]  pc_src, wb_sel, alu_src_a, alu_src_b, shift_op;
  logic [2:0]  alu_op;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] retired_cnt, stall_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int bad;

  logic [24:0] out_vec;
  assign out_vec = {mem_req, mem_we, mem_iord, ir_load, a_load, b_load, aout_load, mdr_load,
                    pc_write, pc_src, reg_write, wb_sel, alu_src_a, alu_src_b, alu_op,
                    shift_op, halted, fault};

  multicycle_ctrl_fsm #(.MEM_TIMEOUT(4), .TO_W(5), .XLEN(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7    (funct7),
    .mem_ready (mem_ready),
    .alu_zero  (alu_zero),
    .alu_lt    (alu_lt),
    .state_out (state_out),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_iord  (mem_iord),
    .ir_load   (ir_load),
    .a_load    (a_load),
    .b_load    (b_load),
    .aout_load (aout_load),
    .mdr_load  (mdr_load),
    .pc_write  (pc_write),
    .pc_src    (pc_src),
    .reg_write (reg_write),
    .wb_sel    (wb_sel),
    .alu_src_a (alu_src_a),
    .alu_src_b (alu_src_b),
    .alu_op    (alu_op),
    .shift_op  (shift_op),
    .halted    (halted),
`ifdef CTRL_PERF_CNT_EN
    .retired_cnt (retired_cnt),
    .stall_cnt   (stall_cnt),
`endif
    .fault     (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Move to just after the next falling edge, where outputs are stable.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // From FETCH: fetch with ready high, decode, land in the dispatch state.
  task automatic fetch_decode(input logic [6:0] op, input logic [2:0] f3,
                              input logic [6:0] f7, input string tag);
    opcode = op; funct3 = f3; funct7 = f7; mem_ready = 1'b1;
    #1;
    chk({tag, "_fetch"}, state_out, 32'd1);
    chk({tag, "_irld"}, ir_load, 32'd1);
    step();
    chk({tag, "_decode"}, state_out, 32'd2);
    step();
  endtask

  task automatic reset_to_fetch();
    reset = 1'b1;
    #1;
    chk("rst_async_state", state_out, 32'd0);
    chk("rst_async_outs", out_vec, 32'd0);
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b1; opcode = '0; funct3 = '0; funct7 = '0;
    mem_ready = 1'b0; alu_zero = 1'b0; alu_lt = 1'b0;
    step(); step();
    chk("rst_state", state_out, 32'd0);
    chk("rst_outs", out_vec, 32'd0);
    reset = 1'b0;
    #1;
    chk("idle_state", state_out, 32'd0);
    chk("idle_outs", out_vec, 32'd0);
    step();

    // add x3,x1,x2
    opcode = 7'b0110011; funct3 = 3'b000; funct7 = 7'b0000000; mem_ready = 1'b1;
    #1;
    chk("add_f_state", state_out, 32'd1);
    chk("add_f_pcw", pc_write, 32'd1);
    chk("add_f_srcb", alu_src_b, 32'd1);
    chk("add_f_aluop", alu_op, 32'd1);
    chk("add_f_memreq", mem_req, 32'd1);
    step();
    chk("add_d_state", state_out, 32'd2);
    chk("add_d_aload", a_load, 32'd1);
    chk("add_d_srcb", alu_src_b, 32'd3);
    step();
    chk("add_e_state", state_out, 32'd3);
    chk("add_e_srca", alu_src_a, 32'd1);
    chk("add_e_aluop", alu_op, 32'd1);
    chk("add_e_regw", reg_write, 32'd0);
    step();
    chk("add_wb_state", state_out, 32'd8);
    chk("add_wb_regw", reg_write, 32'd1);
    step();
    chk("add_next_state", state_out, 32'd1);

    // sub
    fetch_decode(7'b0110011, 3'b000, 7'b0100000, "sub");
    chk("sub_e_state", state_out, 32'd3);
    chk("sub_e_aluop", alu_op, 32'd2);
    step();
    chk("sub_wb_state", state_out, 32'd8);
    step();
`ifdef CTRL_PERF_CNT_EN
    chk("perf_retired2", retired_cnt, 32'd2);
`endif

    // lw with 3 missed ready cycles in FETCH and in MEM_RD
    opcode = 7'b0000011; funct3 = 3'b010; funct7 = 7'b0000000;
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'b0;
      #1;
      chk("lw_fwait_state", state_out, 32'd1);
      chk("lw_fwait_irld", ir_load, 32'd0);
      step();
    end
    mem_ready = 1'b1;
    #1;
    chk("lw_f_irld", ir_load, 32'd1);
    step();
    chk("lw_d_state", state_out, 32'd2);
    step();
    chk("lw_addr_state", state_out, 32'd5);
    chk("lw_addr_srcb", alu_src_b, 32'd2);
    chk("lw_addr_aout", aout_load, 32'd1);
    step();
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'b0;
      #1;
      chk("lw_mwait_state", state_out, 32'd6);
      chk("lw_mwait_mdr", mdr_load, 32'd0);
      chk("lw_mwait_iord", mem_iord, 32'd1);
      step();
    end
    mem_ready = 1'b1;
    #1;
    chk("lw_m_mdr", mdr_load, 32'd1);
    step();
    chk("lw_wb_state", state_out, 32'd9);
    chk("lw_wb_sel", wb_sel, 32'd1);
    chk("lw_wb_mdr", mdr_load, 32'd0);
    step();
    chk("lw_next_state", state_out, 32'd1);
`ifdef CTRL_PERF_CNT_EN
    chk("perf_stall6", stall_cnt, 32'd6);
    chk("perf_retired3", retired_cnt, 32'd3);
`endif

    // sw
    fetch_decode(7'b0100011, 3'b010, 7'b0000000, "sw");
    chk("sw_addr_state", state_out, 32'd5);
    step();
    chk("sw_mw_state", state_out, 32'd7);
    chk("sw_mw_we", mem_we, 32'd1);
    step();

    // beq taken / not taken, blt taken, bge not taken
    fetch_decode(7'b1100011, 3'b000, 7'b0000000, "beqt");
    alu_zero = 1'b1; #1;
    chk("beqt_state", state_out, 32'd10);
    chk("beqt_pcw", pc_write, 32'd1);
    chk("beqt_pcsrc", pc_src, 32'd1);
    chk("beqt_aluop", alu_op, 32'd2);
    step();
    fetch_decode(7'b1100011, 3'b000, 7'b0000000, "beqn");
    alu_zero = 1'b0; #1;
    chk("beqn_pcw", pc_write, 32'd0);
    step();
    fetch_decode(7'b1100011, 3'b100, 7'b0000000, "blt");
    alu_lt = 1'b1; #1;
    chk("blt_aluop", alu_op, 32'd7);
    chk("blt_pcw", pc_write, 32'd1);
    step();
    fetch_decode(7'b1100011, 3'b101, 7'b0000000, "bge");
    #1;
    chk("bge_pcw", pc_write, 32'd0);
    alu_lt = 1'b0;
    step();

    // lui, jal, jalr, addi, srai
    fetch_decode(7'b0110111, 3'b000, 7'b0000000, "lui");
    chk("lui_state", state_out, 32'd11);
    chk("lui_wbsel", wb_sel, 32'd2);
    step();
    fetch_decode(7'b1101111, 3'b000, 7'b0000000, "jal");
    chk("jal_state", state_out, 32'd12);
    chk("jal_pcw", pc_write, 32'd1);
    chk("jal_wbsel", wb_sel, 32'd3);
    chk("jal_pcsrc", pc_src, 32'd1);
    step();
    fetch_decode(7'b1100111, 3'b000, 7'b0000000, "jalr");
    chk("jalr_state", state_out, 32'd13);
    chk("jalr_pcsrc", pc_src, 32'd2);
    chk("jalr_srcb", alu_src_b, 32'd2);
    step();
    fetch_decode(7'b0010011, 3'b000, 7'b0000000, "addi");
    chk("addi_state", state_out, 32'd4);
    chk("addi_srcb", alu_src_b, 32'd2);
    step();
    chk("addi_wb_state", state_out, 32'd8);
    step();
    fetch_decode(7'b0010011, 3'b101, 7'b0100000, "srai");
    chk("srai_state", state_out, 32'd14);
    chk("srai_shop", shift_op, 32'd2);
    chk("srai_regw", reg_write, 32'd1);
    step();
    fetch_decode(7'b0010011, 3'b101, 7'b0000000, "srli");
    chk("srli_shop", shift_op, 32'd1);
    step();

    // R-type 'or' is not supported -> TRAP
    fetch_decode(7'b0110011, 3'b110, 7'b0000000, "ror");
    chk("ror_state", state_out, 32'd31);
    chk("ror_fault", fault, 32'd1);
    reset_to_fetch();

    // Illegal opcode -> TRAP
    fetch_decode(7'b1111111, 3'b000, 7'b0000000, "ill");
    chk("ill_state", state_out, 32'd31);
    chk("ill_fault", fault, 32'd1);
    chk("ill_memreq", mem_req, 32'd0);
    reset_to_fetch();

    // ebreak -> HALT, held for 100 cycles, then async reset
    fetch_decode(7'b1110011, 3'b000, 7'b0000000, "halt");
    chk("halt_state", state_out, 32'd30);
    chk("halt_flag", halted, 32'd1);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (state_out !== 5'd30 || out_vec !== 25'd2) bad++;
    end
    chk("halt_hold", bad, 32'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("halt_rst_state", state_out, 32'd0);
    chk("halt_rst_flag", halted, 32'd0);
    step();
    reset = 1'b0;
    step();

    // Memory timeout in FETCH: 4 ready-less cycles, then TRAP
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("to_wait_state", state_out, 32'd1);
      step();
    end
    chk("to_state", state_out, 32'd31);
    chk("to_fault", fault, 32'd1);
    chk("to_memreq", mem_req, 32'd0);
    step();
    chk("to_memreq_hold", mem_req, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
